// File: rtl/triangle_fetcher.sv
// triangle_fetcher: walks the triangle table once per frame pass, translates every
// vertex into camera space (vertex - camera), culls triangles that are behind the
// near plane or whose translated coordinates overflow 16 bits, and streams each
// surviving triangle to the projector as three back-to-back vertex beats.
//
// Ports
//   clk, rst         clock and synchronous active-high reset
//   start            one-cycle pulse starting a pass (ignored while busy)
//   num_triangles    triangle count, latched on accepted start
//   camera_x/y/z     signed camera position, latched on accepted start
//   mem_addr         triangle table read address (held stable during a fetch)
//   mem_data         {color, v1{x,y,z}, v2, v3}, valid MEM_LATENCY cycles after mem_addr
//   vertex, color    camera-space vertex beat and triangle colour (0 outside beats)
//   new_triangle     marks the first of the three beats
//   done_out         one-cycle end-of-pass pulse
//   busy             pass in progress, up to and including the done_out cycle
//   culled_count     triangles culled in the current/last pass
module triangle_fetcher #(
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter int unsigned MEM_LATENCY = 2,
    parameter int          NEAR_Z      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   num_triangles,
    input  logic [15:0]           camera_x,
    input  logic [15:0]           camera_y,
    input  logic [15:0]           camera_z,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [159:0]          mem_data,
    output logic [47:0]           vertex,
    output logic [15:0]           color,
    output logic                  new_triangle,
    output logic                  done_out,
    output logic                  busy,
    output logic [ADDR_WIDTH:0]   culled_count
);

    localparam int unsigned LatW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic signed [16:0] NearZ = 17'(NEAR_Z);

    typedef enum logic [2:0] {
        StIdle, StFetch, StCheck, StEmit0, StEmit1, StEmit2, StDone
    } state_e;

    state_e              state;
    logic [ADDR_WIDTH:0] idx;
    logic [ADDR_WIDTH:0] num_q;
    logic [15:0]         cam_x, cam_y, cam_z;
    logic [LatW-1:0]     lat_cnt;
    logic [47:0]         v2_q, v3_q;

    logic signed [16:0]  dx [3];
    logic signed [16:0]  dy [3];
    logic signed [16:0]  dz [3];
    logic [15:0]         vx, vy, vz;
    logic [47:0]         tv [3];
    logic                cull;
    logic                is_last;

    // Translation is done in 17 bits so a coordinate that no longer fits in
    // 16 signed bits shows up as bit16 != bit15.
    always_comb begin
        cull = 1'b0;
        vx   = '0;
        vy   = '0;
        vz   = '0;
        for (int i = 0; i < 3; i++) begin
            vx    = mem_data[143 - 48*i -: 16];
            vy    = mem_data[127 - 48*i -: 16];
            vz    = mem_data[111 - 48*i -: 16];
            dx[i] = {vx[15], vx} - {cam_x[15], cam_x};
            dy[i] = {vy[15], vy} - {cam_y[15], cam_y};
            dz[i] = {vz[15], vz} - {cam_z[15], cam_z};
            tv[i] = {dx[i][15:0], dy[i][15:0], dz[i][15:0]};
            if ((dx[i][16] != dx[i][15]) || (dy[i][16] != dy[i][15]) ||
                (dz[i][16] != dz[i][15]) || (dz[i] < NearZ)) begin
                cull = 1'b1;
            end
        end
    end

    // idx is one bit wider than mem_addr so a full table (2^ADDR_WIDTH entries)
    // terminates on the compare rather than wrapping.
    assign is_last = (idx == num_q - 1'b1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= StIdle;
            idx          <= '0;
            num_q        <= '0;
            cam_x        <= '0;
            cam_y        <= '0;
            cam_z        <= '0;
            lat_cnt      <= '0;
            v2_q         <= '0;
            v3_q         <= '0;
            mem_addr     <= '0;
            vertex       <= '0;
            color        <= '0;
            new_triangle <= 1'b0;
            done_out     <= 1'b0;
            busy         <= 1'b0;
            culled_count <= '0;
        end else begin
            case (state)
                StIdle: begin
                    if (start) begin
                        cam_x        <= camera_x;
                        cam_y        <= camera_y;
                        cam_z        <= camera_z;
                        num_q        <= num_triangles;
                        culled_count <= '0;
                        idx          <= '0;
                        mem_addr     <= '0;
                        lat_cnt      <= '0;
                        busy         <= 1'b1;
                        if (num_triangles == '0) begin
                            state    <= StDone;
                            done_out <= 1'b1;
                        end else begin
                            state    <= StFetch;
                        end
                    end
                end
                StFetch: begin
                    if (lat_cnt == LatW'(MEM_LATENCY - 1)) begin
                        state <= StCheck;
                    end else begin
                        lat_cnt <= lat_cnt + 1'b1;
                    end
                end
                StCheck: begin
                    if (cull) begin
                        culled_count <= culled_count + 1'b1;
                        if (is_last) begin
                            state    <= StDone;
                            done_out <= 1'b1;
                        end else begin
                            idx      <= idx + 1'b1;
                            mem_addr <= ADDR_WIDTH'(idx + 1'b1);
                            lat_cnt  <= '0;
                            state    <= StFetch;
                        end
                    end else begin
                        vertex       <= tv[0];
                        v2_q         <= tv[1];
                        v3_q         <= tv[2];
                        color        <= mem_data[159:144];
                        new_triangle <= 1'b1;
                        state        <= StEmit0;
                    end
                end
                StEmit0: begin
                    vertex       <= v2_q;
                    new_triangle <= 1'b0;
                    state        <= StEmit1;
                end
                StEmit1: begin
                    vertex <= v3_q;
                    state  <= StEmit2;
                end
                StEmit2: begin
                    vertex <= '0;
                    color  <= '0;
                    if (is_last) begin
                        state    <= StDone;
                        done_out <= 1'b1;
                    end else begin
                        idx      <= idx + 1'b1;
                        mem_addr <= ADDR_WIDTH'(idx + 1'b1);
                        lat_cnt  <= '0;
                        state    <= StFetch;
                    end
                end
                StDone: begin
                    done_out <= 1'b0;
                    busy     <= 1'b0;
                    state    <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_triangle_fetcher.sv
// Scoreboard bench for triangle_fetcher: stimulus pushes expected beats/done events
// (with the cycle they must appear in) into queues; negedge monitors pop and compare.
// A second instance (MEM_LATENCY=3, ADDR_WIDTH=2) covers the full-table pass.
module tb_triangle_fetcher;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Main instance, L=2
    logic         rst, start;
    logic [10:0]  num;
    logic [15:0]  cx, cy, cz;
    logic [9:0]   maddr;
    logic [159:0] mdata;
    logic [47:0]  vtx;
    logic [15:0]  col;
    logic         nt, done, bsy;
    logic [10:0]  culled;

    triangle_fetcher #(.ADDR_WIDTH(10), .MEM_LATENCY(2), .NEAR_Z(16)) dut (
        .clk(clk), .rst(rst), .start(start), .num_triangles(num),
        .camera_x(cx), .camera_y(cy), .camera_z(cz),
        .mem_addr(maddr), .mem_data(mdata), .vertex(vtx), .color(col),
        .new_triangle(nt), .done_out(done), .busy(bsy), .culled_count(culled)
    );

    logic [159:0] tbl [1024];
    logic [159:0] pipe2 [2];
    always @(posedge clk) begin
        pipe2[0] <= tbl[maddr];
        pipe2[1] <= pipe2[0];
    end
    assign mdata = pipe2[1];

    // Second instance, L=3, 4-entry table
    logic         start3;
    logic [2:0]   num3;
    logic [15:0]  zero16 = 16'h0;
    logic [1:0]   maddr3;
    logic [159:0] mdata3;
    logic [47:0]  vtx3;
    logic [15:0]  col3;
    logic         nt3, done3, bsy3;
    logic [2:0]   culled3;

    triangle_fetcher #(.ADDR_WIDTH(2), .MEM_LATENCY(3), .NEAR_Z(16)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .num_triangles(num3),
        .camera_x(zero16), .camera_y(zero16), .camera_z(zero16),
        .mem_addr(maddr3), .mem_data(mdata3), .vertex(vtx3), .color(col3),
        .new_triangle(nt3), .done_out(done3), .busy(bsy3), .culled_count(culled3)
    );

    logic [159:0] tbl3 [4];
    logic [159:0] pipe3 [3];
    always @(posedge clk) begin
        pipe3[0] <= tbl3[maddr3];
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
    end
    assign mdata3 = pipe3[2];

    // Scoreboard queues
    typedef struct { int cyc; logic [15:0] col; logic [47:0] v1, v2, v3; } tri_t;
    typedef struct { int cyc; logic [10:0] culled; } done_t;
    tri_t  tri_q  [$];
    done_t done_q [$];
    tri_t  t3_q   [$];
    int    done3_cyc = -1;
    int    nt3_count = 0;

    // Monitor for main instance
    int    beat = 0;
    tri_t  cur;
    done_t dexp;
    always @(negedge clk) begin
        if (rst) begin
            beat = 0;
        end else begin
            if (nt) begin
                chk("beat_overlap", 64'(beat), 0);
                chk("tri_expected", 64'(tri_q.size() != 0), 1);
                if (tri_q.size() != 0) begin
                    cur = tri_q.pop_front();
                    chk("tri_cycle", 64'(cyc), 64'(cur.cyc));
                    chk("beat0_color", col, cur.col);
                    chk("beat0_vertex", vtx, cur.v1);
                end
                beat = 1;
            end else if (beat != 0) begin
                chk("beat_color", col, cur.col);
                chk("beat_vertex", vtx, (beat == 1) ? cur.v2 : cur.v3);
                beat = (beat == 2) ? 0 : beat + 1;
            end else begin
                chk("idle_vertex_color", {vtx, col}, 0);
            end
            if (done) begin
                chk("done_expected", 64'(done_q.size() != 0), 1);
                if (done_q.size() != 0) begin
                    dexp = done_q.pop_front();
                    chk("done_cycle", 64'(cyc), 64'(dexp.cyc));
                    chk("culled_count", culled, dexp.culled);
                    chk("busy_at_done", bsy, 1);
                end
            end
        end
    end

    // Monitor for L=3 instance
    tri_t e3;
    always @(negedge clk) begin
        if (!rst && nt3) begin
            nt3_count++;
            chk("l3_tri_expected", 64'(t3_q.size() != 0), 1);
            if (t3_q.size() != 0) begin
                e3 = t3_q.pop_front();
                chk("l3_tri_cycle", 64'(cyc), 64'(e3.cyc));
                chk("l3_color", col3, e3.col);
                chk("l3_vertex", vtx3, e3.v1);
            end
        end
        if (!rst && done3) begin
            chk("l3_done_cycle", 64'(cyc), 64'(done3_cyc));
            chk("l3_culled", culled3, 0);
        end
    end

    function automatic logic [47:0] mkv(input int x, input int y, input int z);
        return {16'(x), 16'(y), 16'(z)};
    endfunction

    function automatic logic [159:0] mkt(input logic [15:0] c, input logic [47:0] a,
                                         input logic [47:0] b, input logic [47:0] d);
        return {c, a, b, d};
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_tri(input int c, input logic [15:0] k, input logic [47:0] a,
                            input logic [47:0] b, input logic [47:0] d);
        tri_t t;
        t = '{c, k, a, b, d};
        tri_q.push_back(t);
    endtask

    task automatic push_done(input int c, input logic [10:0] k);
        done_t d;
        d = '{c, k};
        done_q.push_back(d);
    endtask

    // Issues a start in the current cycle; returns one cycle later.
    task automatic go(input logic [10:0] n, input int x, input int y, input int z);
        chk("idle_before_start", bsy, 0);
        num   = n;
        cx    = 16'(x);
        cy    = 16'(y);
        cz    = 16'(z);
        start = 1'b1;
        step(1);
        start = 1'b0;
        chk("busy_after_start", bsy, 1);
    endtask

    int c0;

    initial begin
        rst = 1'b1; start = 1'b0; num = '0; cx = '0; cy = '0; cz = '0;
        start3 = 1'b0; num3 = '0;
        step(3);
        chk("rst_vertex", vtx, 0);
        chk("rst_misc", {maddr, col, nt, done, bsy, culled}, 0);
        rst = 1'b0;
        step(1);

        // 1: single kept triangle, camera at origin
        tbl[0] = mkt(16'hF800, mkv(10, 20, 100), mkv(-5, 0, 200), mkv(0, -7, 50));
        c0 = cyc;
        push_tri(c0 + 4, 16'hF800, mkv(10, 20, 100), mkv(-5, 0, 200), mkv(0, -7, 50));
        push_done(c0 + 7, 0);
        go(1, 0, 0, 0);
        step(8);
        chk("busy_after_pass1", bsy, 0);

        // 2: camera offset, dz==16 kept, camera change mid-pass ignored
        tbl[0] = mkt(16'h07E0, mkv(110, -40, 120), mkv(100, -50, 36), mkv(-200, 0, 1000));
        c0 = cyc;
        push_tri(c0 + 4, 16'h07E0, 48'h000A_000A_0064, 48'h0000_0000_0010,
                 48'hFED4_0032_03D4);
        push_done(c0 + 7, 0);
        go(1, 100, -50, 20);
        cx = 16'h7FFF; cz = 16'h7FFF;
        step(8);

        // 3: three triangles, middle one has dz=15
        tbl[0] = mkt(16'h1111, mkv(1, 2, 20), mkv(3, 4, 21), mkv(5, 6, 22));
        tbl[1] = mkt(16'h2222, mkv(0, 0, 100), mkv(0, 0, 19), mkv(0, 0, 100));
        tbl[2] = mkt(16'h3333, mkv(7, 8, 24), mkv(9, 10, 34), mkv(-1, -2, 44));
        c0 = cyc;
        push_tri(c0 + 4, 16'h1111, mkv(1, 2, 16), mkv(3, 4, 17), mkv(5, 6, 18));
        push_tri(c0 + 13, 16'h3333, mkv(7, 8, 20), mkv(9, 10, 30), mkv(-1, -2, 40));
        push_done(c0 + 16, 1);
        go(3, 0, 0, 4);
        step(6);
        chk("mem_addr_tri1", maddr, 1);
        step(11);

        // 4: x overflow culled, d=32767 kept; then an empty pass
        tbl[0] = mkt(16'hABCD, mkv(32767, 0, 100), mkv(0, 0, 100), mkv(0, 0, 100));
        tbl[1] = mkt(16'h5555, mkv(-1, 0, 50), mkv(-32768, 0, 60), mkv(-100, 0, 70));
        c0 = cyc;
        push_tri(c0 + 7, 16'h5555, mkv(32767, 0, 50), mkv(0, 0, 60), mkv(32668, 0, 70));
        push_done(c0 + 10, 1);
        go(2, -32768, 0, 0);
        step(11);
        c0 = cyc;
        push_done(c0 + 1, 0);
        go(0, 0, 0, 0);
        step(1);
        chk("busy_after_empty", bsy, 0);
        step(1);

        // 5: reset during EMIT1 aborts the pass
        tbl[0] = mkt(16'hF800, mkv(10, 20, 100), mkv(-5, 0, 200), mkv(0, -7, 50));
        c0 = cyc;
        push_tri(c0 + 4, 16'hF800, mkv(10, 20, 100), mkv(-5, 0, 200), mkv(0, -7, 50));
        go(1, 0, 0, 0);
        step(4);
        rst = 1'b1;
        step(1);
        chk("abort_vertex", vtx, 0);
        chk("abort_misc", {maddr, col, nt, done, bsy, culled}, 0);
        rst = 1'b0;
        step(10);

        // 5b: starts while busy (mid-pass and in the DONE cycle) are ignored
        c0 = cyc;
        push_tri(c0 + 4, 16'hF800, mkv(10, 20, 100), mkv(-5, 0, 200), mkv(0, -7, 50));
        push_done(c0 + 7, 0);
        go(1, 0, 0, 0);
        step(2);
        num = 0; start = 1'b1;
        step(1);
        start = 1'b0;
        step(3);
        num = 1; start = 1'b1;
        step(1);
        start = 1'b0;
        chk("busy_after_ignored_start", bsy, 0);
        step(3);
        c0 = cyc;
        push_tri(c0 + 4, 16'hF800, mkv(10, 20, 100), mkv(-5, 0, 200), mkv(0, -7, 50));
        push_done(c0 + 7, 0);
        go(1, 0, 0, 0);
        step(8);

        // 6: L=3, full 4-entry table, all kept
        for (int i = 0; i < 4; i++) begin
            tbl3[i] = mkt(16'hA000 + 16'(i), mkv(i, 1, 100), mkv(2, i, 200), mkv(3, 3, 300));
        end
        c0 = cyc;
        for (int i = 0; i < 4; i++) begin
            tri_t t;
            t = '{c0 + 5 + 7 * i, 16'hA000 + 16'(i), mkv(i, 1, 100), 48'h0, 48'h0};
            t3_q.push_back(t);
        end
        done3_cyc = c0 + 29;
        num3 = 3'd4; start3 = 1'b1;
        step(1);
        start3 = 1'b0;
        chk("l3_busy_after_start", bsy3, 1);
        step(31);
        chk("l3_triangles", 64'(nt3_count), 4);
        chk("l3_busy_end", bsy3, 0);

        chk("tri_q_drained", 64'(tri_q.size()), 0);
        chk("done_q_drained", 64'(done_q.size()), 0);
        chk("l3_q_drained", 64'(t3_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
